// File: rtl/cache_req_queue.sv
// cache_req_queue: FIFO of CPU requests issued one at a time to a cache controller.
// Define CC_TIMEOUT_EN to compile in the WAIT-state watchdog and sticky timeout_err.
module cache_req_queue #(
   parameter int DEPTH         = 4,
   parameter int ADDRESSLENGTH = 16,
   parameter int DATALENGTH    = 32,
   parameter int TIMEOUT       = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDRESSLENGTH-1:0] req_addr,
   input  logic [DATALENGTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   output logic                     rsp_we,
   output logic [DATALENGTH-1:0]    rsp_rdata,
   output logic                     cc_re,
   output logic                     cc_we,
   output logic [ADDRESSLENGTH-1:0] cc_addr,
   output logic [DATALENGTH-1:0]    cc_wdata,
   input  logic [DATALENGTH-1:0]    cc_rdata,
   input  logic                     cc_ready,
   output logic                     timeout_err
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [DEPTH-1:0] mem_we;
   logic [ADDRESSLENGTH-1:0] mem_addr [DEPTH];
   logic [DATALENGTH-1:0] mem_wdata [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   logic cur_we, push, pop, expire;
   assign req_ready = count != (PW+1)'(DEPTH);
   assign push = req_valid && req_ready;
   assign pop = state == WAIT && (cc_ready || expire);
`ifdef CC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;
   // timer holds the number of completed WAIT cycles; abort at the end of the TIMEOUT-th
   assign expire = state == WAIT && !cc_ready && timer == TW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (!reset) begin
         timer <= '0;
         timeout_err <= 1'b0;
      end else begin
         timer <= (state == ISSUE) ? '0 : (state == WAIT) ? timer + 1'b1 : timer;
         if (expire) timeout_err <= 1'b1;
      end
   end
`else
   assign expire = 1'b0;
   assign timeout_err = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == IDLE && count != '0) ? ISSUE :
                  (state == ISSUE)               ? WAIT  :
                  pop                            ? RESP  :
                  (state == RESP)                ? IDLE  : state;
      cc_re = state == ISSUE && !cur_we;
      cc_we = state == ISSUE && cur_we;
      rsp_valid = state == RESP;
      rsp_we = state == RESP && cur_we;
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_we[wr_ptr] <= req_we;
         mem_addr[wr_ptr] <= req_addr;
         mem_wdata[wr_ptr] <= req_wdata;
      end
   end
   // the head entry stays queued until the controller completes it
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         cur_we <= 1'b0;
         cc_addr <= '0;
         cc_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (state == IDLE && count != '0) begin
            cur_we <= mem_we[rd_ptr];
            cc_addr <= mem_addr[rd_ptr];
            cc_wdata <= mem_wdata[rd_ptr];
         end
         if (pop) rsp_rdata <= (cur_we || expire) ? '0 : cc_rdata;
      end
   end
endmodule
